bus_rx_capture: RTL
===================

# bus_rx_capture

Strobed bus receiver for the CPU board's shared 8-bit tri-state data bus: the receiving end of the octal bus-driver path. It synchronises an asynchronous, active-low write strobe, samples the bus only while the driver's output enable is asserted, and buffers up to two words in a valid/ready queue for the local consumer. It flags protocol errors: overrun when the queue is full, and a float error when strobed while the bus is undriven.

## Interface
- DW, 8, bus/data width in bits
- sysclk  input  1  system clock; all state changes on the rising edge
- sys_rst_n  input  1  synchronous, active-low reset
- BUS_D  input  DW  shared tri-state data bus, asynchronous to sysclk
- BUS_G_n  input  1  driver output enable (active low); low means BUS_D is driven
- STB_n  input  1  asynchronous write strobe, active low; idle high
- DOUT  output  DW  head-of-queue data word
- DVALID  output  1  DOUT holds a valid word
- DREADY  input  1  consumer accepts DOUT when DVALID and DREADY are both high at a rising edge
- OVR  output  1  sticky overrun flag
- FLT  output  1  sticky float error flag: strobe seen with the bus undriven
- CLR_ERR  input  1  synchronous clear of OVR and FLT
- LEVEL  output  2  queue occupancy, 0 to 2

## Operation
- Input capture: STB_n, BUS_G_n and BUS_D pass together through two register stages (s1, s2). A third register, s3, holds STB_n only. Data and enable stay aligned with the strobe.
- Strobe event: a falling edge is detected as s3 = 1 and s2(STB_n) = 0. Exactly one event is produced per low pulse, however long the pulse is.
- Event with s2(BUS_G_n) = 0: push s2(BUS_D) into the queue.
- Event with s2(BUS_G_n) = 1: no push; set FLT.
- Queue: 2-entry FIFO. The state machine has three states.
  - EMPTY: push goes to ONE.
  - ONE: push alone goes to FULL; pop alone goes to EMPTY; push and pop together stay in ONE, and DOUT takes the pushed word.
  - FULL: pop alone goes to ONE; push and pop together stay in FULL, the old tail becomes the head and the new word becomes the tail; push alone is dropped, OVR is set, and the contents are unchanged.
- Pop = DVALID & DREADY. DREADY has no effect when DVALID = 0.
- DVALID = (state != EMPTY). LEVEL encodes 0, 1, 2.
- DOUT is held stable while DVALID = 1 and there is no pop. DOUT is undefined-stable (retains its last value) when the queue is EMPTY.
- OVR and FLT are sticky until CLR_ERR. If CLR_ERR and a new error event fall in the same cycle, the flag stays set: set wins.
- Reset values: state EMPTY, DVALID 0, LEVEL 0, DOUT 0, OVR 0, FLT 0, s1, s2 and s3 strobe bits 1, other synchroniser bits 0. The strobe bits reset to 1 so that no false event occurs after reset.
- Reset mid-operation: the queue is flushed and the flags are cleared. A strobe held low through reset release produces no event until it goes high and then low again.

## Timing
- STB_n first sampled low at rising edge k: s2 is low after k+1; push at edge k+2; DVALID = 1 after edge k+2. Latency is 3 edges counted from edge k.
- BUS_D and BUS_G_n must be stable from the edge that first samples STB_n low through the following edge. The bus driver holds the bus during the strobe.
- Minimum STB_n low time: 2 sysclk periods. Minimum high time between strobes: 2 sysclk periods. A sustained rate of one strobe every 4 cycles is lossless if DREADY is held high.
- A pop and a push in the same cycle both take effect at the same edge. LEVEL updates at that edge.
- OVR and FLT are set at the same edge as the push would have occurred.

## Structure
- Shared package nd_bus_pkg: BUS_W = 8; FIFO depth constant RXQ_DEPTH = 2; the queue state enum {EMPTY, ONE, FULL}.
- Sub-module bus_rx_sync: the s1/s2/s3 pipeline for STB_n, BUS_G_n and BUS_D. Outputs are the event pulse, the aligned data and the aligned enable.
- Top level: queue state machine, 2 × DW storage, error flags.

## Test plan
- Single write: BUS_G_n = 0, BUS_D = 8'hA5, STB_n low for 3 cycles, DREADY = 0 -> DVALID rises 3 edges after the first low sample; DOUT = A5; LEVEL = 1; exactly one push.
- Fill and overrun: strobe 8'h11, 8'h22, 8'h33 with DREADY = 0 -> LEVEL = 2 and OVR = 1. Then with DREADY = 1, pop 11 then 22. 33 is never output.
- Simultaneous push/pop when FULL: queue holds {11, 22}; strobe 44 timed so the push lands on a pop edge -> LEVEL stays 2; output order is 22 then 44; OVR = 0.
- Float error: BUS_G_n = 1, strobe with BUS_D = 8'hFF -> no push; LEVEL = 0; FLT = 1. CLR_ERR pulse -> FLT = 0. CLR_ERR on the same edge as a new float event -> FLT = 1.
- Reset mid-stream: queue holds 2 words, then sys_rst_n is held low 1 cycle while STB_n is low -> DVALID = 0, LEVEL = 0, flags 0. No push until STB_n goes high and then low again.
- Back-to-back strobes: 2 low / 2 high cycles, 8 words 00 to 07, DREADY = 1 -> all 8 words received in order; OVR = 0.

Source files
------------

// File: rtl/nd_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nd_bus_pkg
// Description : Shared constants and types for the CPU-board data bus
//               receive path.
//               BUS_W       - width of the shared data bus
//               RXQ_DEPTH   - receive queue depth in words
//               rxq_state_e - receive queue occupancy state
// Revision    : 1.0 - initial release
// ============================================================================
package nd_bus_pkg;

  localparam int BUS_W     = 8;
  localparam int RXQ_DEPTH = 2;

  // The encoding equals the number of words held, so it doubles as LEVEL.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } rxq_state_e;

  function automatic logic [1:0] rxq_level(input rxq_state_e s);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : bus_rx_sync
// Description : Two-stage capture of the asynchronous strobe, enable and
//               data bus, plus a third strobe stage for falling-edge
//               detection. Produces one event pulse per strobe low pulse.
// Ports       : clk       - system clock
//               rst_n     - synchronous active-low reset
//               stb_n     - asynchronous write strobe (active low)
//               g_n       - bus driver output enable (active low)
//               d         - bus data
//               stb_event - one-cycle pulse per strobe falling edge
//               g_n_al    - enable aligned with stb_event
//               d_al      - data aligned with stb_event
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rx_sync #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stb_n,
  input  logic          g_n,
  input  logic [DW-1:0] d,
  output logic          stb_event,
  output logic          g_n_al,
  output logic [DW-1:0] d_al
);

  logic          s1_stb, s2_stb, s3_stb;
  logic          s1_g, s2_g;
  logic [DW-1:0] s1_d, s2_d;
  // real1/real2 mark that s1/s2 hold genuine post-reset samples rather than
  // reset values; armed is set once a genuine high strobe reached s3. This
  // stops a strobe held low across reset release from firing an event.
  logic          real1, real2;
  logic          armed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_stb <= 1'b1;
      s2_stb <= 1'b1;
      s3_stb <= 1'b1;
      s1_g   <= 1'b0;
      s2_g   <= 1'b0;
      s1_d   <= '0;
      s2_d   <= '0;
      real1  <= 1'b0;
      real2  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      s1_stb <= stb_n;
      s2_stb <= s1_stb;
      s3_stb <= s2_stb;
      s1_g   <= g_n;
      s2_g   <= s1_g;
      s1_d   <= d;
      s2_d   <= s1_d;
      real1  <= 1'b1;
      real2  <= real1;
      armed  <= armed | (real2 & s2_stb);
    end
  end

  assign stb_event = armed & s3_stb & ~s2_stb;
  assign g_n_al    = s2_g;
  assign d_al      = s2_d;

endmodule
`default_nettype wire

// File: rtl/bus_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : bus_rx_capture
// Description : Strobed receiver for the shared tri-state data bus. Captures
//               a word on each strobe while the bus is driven, buffers up to
//               two words for a valid/ready consumer, and flags overrun and
//               float errors (sticky until CLR_ERR).
// Ports       : sysclk    - system clock
//               sys_rst_n - synchronous active-low reset
//               BUS_D     - shared data bus (asynchronous)
//               BUS_G_n   - driver output enable, low = bus driven
//               STB_n     - asynchronous write strobe, active low
//               DOUT      - head-of-queue word
//               DVALID    - DOUT is valid
//               DREADY    - consumer accepts DOUT
//               OVR       - sticky overrun flag
//               FLT       - sticky float error flag
//               CLR_ERR   - clears OVR and FLT (a new error wins)
//               LEVEL     - queue occupancy 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rx_capture
  import nd_bus_pkg::*;
#(
  parameter int DW = BUS_W
) (
  input  logic          sysclk,
  input  logic          sys_rst_n,
  input  logic [DW-1:0] BUS_D,
  input  logic          BUS_G_n,
  input  logic          STB_n,
  output logic [DW-1:0] DOUT,
  output logic          DVALID,
  input  logic          DREADY,
  output logic          OVR,
  output logic          FLT,
  input  logic          CLR_ERR,
  output logic [1:0]    LEVEL
);

  logic          stb_event;
  logic          g_n_al;
  logic [DW-1:0] d_al;

  bus_rx_sync #(.DW(DW)) u_sync (
    .clk       (sysclk),
    .rst_n     (sys_rst_n),
    .stb_n     (STB_n),
    .g_n       (BUS_G_n),
    .d         (BUS_D),
    .stb_event (stb_event),
    .g_n_al    (g_n_al),
    .d_al      (d_al)
  );

  rxq_state_e    state, state_nxt;
  logic [DW-1:0] slot [RXQ_DEPTH];   // slot[0] = head, slot[1] = tail
  logic          push, pop, ovr_set, flt_set;

  assign push    = stb_event & ~g_n_al;
  assign flt_set = stb_event &  g_n_al;
  assign pop     = DVALID & DREADY;
  assign ovr_set = push & ~pop & (state == FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE:     if (push && !pop) state_nxt = FULL;
               else if (!push && pop) state_nxt = EMPTY;
      FULL:    if (!push && pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      state   <= EMPTY;
      slot[0] <= '0;
      slot[1] <= '0;
      DVALID  <= 1'b0;
      LEVEL   <= 2'd0;
      OVR     <= 1'b0;
      FLT     <= 1'b0;
    end else begin
      state  <= state_nxt;
      DVALID <= (state_nxt != EMPTY);
      LEVEL  <= rxq_level(state_nxt);
      case (state)
        EMPTY: if (push) slot[0] <= d_al;
        ONE: begin
          // push with pop replaces the head; push alone fills the tail
          if (push && pop)  slot[0] <= d_al;
          else if (push)    slot[1] <= d_al;
        end
        FULL: begin
          // any pop advances the tail; a push alone is dropped
          if (pop) begin
            slot[0] <= slot[1];
            if (push) slot[1] <= d_al;
          end
        end
        default: ;
      endcase
      OVR <= ovr_set | (OVR & ~CLR_ERR);
      FLT <= flt_set | (FLT & ~CLR_ERR);
    end
  end

  assign DOUT = slot[0];

endmodule
`default_nettype wire
